// File: rtl/i2c_master_write.sv
// I2C write-only bus controller: START, address+W, register byte, data byte, STOP.
// SCL is built from quarter ticks of the system clock; any NACK aborts straight to STOP.
module i2c_master_write #(
    parameter int         CLK_DIV    = 4,
    parameter logic [6:0] SLAVE_ADDR = 7'h47
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] reg_addr,
    input  logic [7:0] data_in,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic       busy,
    output logic       done,
    output logic       nack
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        STOP,
        DONE
    } state_t;

    localparam int            QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(CLK_DIV - 1);

    state_t        state;
    logic [QW-1:0] qcnt;
    logic [1:0]    phase;
    logic [23:0]   shift;
    logic [3:0]    bit_cnt;
    logic [1:0]    byte_cnt;

    logic tick;
    logic ack_slot;
    logic last_slot;

    assign tick      = (qcnt == QLAST);
    assign ack_slot  = (bit_cnt == 4'd8);
    assign last_slot = ack_slot && (byte_cnt == 2'd2);

    // Outputs for each quarter are loaded on the tick that enters it, so every
    // bus level is registered and holds for exactly one quarter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            qcnt     <= '0;
            phase    <= 2'd0;
            shift    <= '0;
            bit_cnt  <= 4'd0;
            byte_cnt <= 2'd0;
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            nack     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state inside {START, BIT, STOP}) begin
                qcnt <= tick ? '0 : qcnt + QW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= START;
                        phase    <= 2'd0;
                        qcnt     <= '0;
                        shift    <= {SLAVE_ADDR, 1'b0, reg_addr, data_in};
                        bit_cnt  <= 4'd0;
                        byte_cnt <= 2'd0;
                        scl_o    <= 1'b1;
                        sda_o    <= 1'b1;
                        busy     <= 1'b1;
                        nack     <= 1'b0;
                    end
                end

                START: begin
                    if (tick) begin
                        if (phase == 2'd0) begin
                            phase <= 2'd1;
                            sda_o <= 1'b0;
                        end else begin
                            state    <= BIT;
                            phase    <= 2'd0;
                            scl_o    <= 1'b0;
                            sda_o    <= shift[23];
                            shift    <= {shift[22:0], 1'b0};
                            bit_cnt  <= 4'd0;
                            byte_cnt <= 2'd0;
                        end
                    end
                end

                BIT: begin
                    if (tick) begin
                        case (phase)
                            2'd0: phase <= 2'd1;
                            2'd1: begin
                                phase <= 2'd2;
                                scl_o <= 1'b1;
                            end
                            2'd2: begin
                                phase <= 2'd3;
                                if (ack_slot && sda_i) begin
                                    nack <= 1'b1;
                                end
                            end
                            default: begin
                                // nack can only have been raised in this slot's Q2,
                                // so it doubles as the abort request.
                                phase <= 2'd0;
                                scl_o <= 1'b0;
                                if (nack || last_slot) begin
                                    state <= STOP;
                                    sda_o <= 1'b0;
                                end else if (ack_slot) begin
                                    bit_cnt  <= 4'd0;
                                    byte_cnt <= byte_cnt + 2'd1;
                                    sda_o    <= shift[23];
                                    shift    <= {shift[22:0], 1'b0};
                                end else if (bit_cnt == 4'd7) begin
                                    bit_cnt <= 4'd8;
                                    sda_o   <= 1'b1;
                                end else begin
                                    bit_cnt <= bit_cnt + 4'd1;
                                    sda_o   <= shift[23];
                                    shift   <= {shift[22:0], 1'b0};
                                end
                            end
                        endcase
                    end
                end

                STOP: begin
                    if (tick) begin
                        case (phase)
                            2'd0: begin
                                phase <= 2'd1;
                                scl_o <= 1'b1;
                            end
                            2'd1: begin
                                phase <= 2'd2;
                                sda_o <= 1'b1;
                            end
                            default: begin
                                state <= DONE;
                                phase <= 2'd0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        endcase
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_write.sv
// Scoreboard bench for i2c_master_write: a target model ACKs selected slots, a monitor
// checks every SCL-rise bit and every done pulse against queued expectations.
module tb_i2c_master_write;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       pull = 1'b0;
    logic [2:0] ack_mask = 3'b111;

    logic start4, start1, sda_i;
    logic scl4, sda4, busy4, done4, nack4;
    logic scl1, sda1, busy1, done1, nack1;
    logic m_scl, m_sda_o, m_sda, m_busy, m_done, m_nack;

    int   cyc = 0;
    int   start_cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   done_count = 0;
    int   falls = 0;
    int   slot = 0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic active = 1'b0;
    logic busy_gap = 1'b0;
    logic exp_b;
    int   exp_c;
    logic exp_n;

    logic exp_bits[$];
    int   exp_cyc[$];
    logic exp_nk[$];

    assign start4  = start & ~sel;
    assign start1  = start & sel;
    assign m_scl   = sel ? scl1 : scl4;
    assign m_sda_o = sel ? sda1 : sda4;
    assign m_busy  = sel ? busy1 : busy4;
    assign m_done  = sel ? done1 : done4;
    assign m_nack  = sel ? nack1 : nack4;
    assign m_sda   = m_sda_o & ~pull;
    assign sda_i   = m_sda;

    i2c_master_write #(.CLK_DIV(4), .SLAVE_ADDR(7'h47)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .reg_addr(reg_addr), .data_in(data_in),
        .sda_i(sda_i), .scl_o(scl4), .sda_o(sda4), .busy(busy4), .done(done4), .nack(nack4)
    );

    i2c_master_write #(.CLK_DIV(1), .SLAVE_ADDR(7'h47)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .reg_addr(reg_addr), .data_in(data_in),
        .sda_i(sda_i), .scl_o(scl1), .sda_o(sda1), .busy(busy1), .done(done1), .nack(nack1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc - start_cyc);
    endtask

    // Queues the bit stream and done timing a real transaction must produce, then
    // pulses start on the current negedge.
    task automatic applyStimulus(input logic [7:0] ra, input logic [7:0] d, input logic [2:0] mask);
        logic [23:0] bytes;
        int          q;
        int          k;
        bytes = {8'h8E, ra, d};
        q = sel ? 1 : 4;
        k = 0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) exp_bits.push_back(bytes[23 - 8 * b - i]);
            exp_bits.push_back(~mask[b]);
            k = b + 1;
            if (!mask[b]) break;
        end
        exp_bits.push_back(1'b0);
        exp_cyc.push_back((5 + 36 * k) * q + 1);
        exp_nk.push_back(mask != 3'b111);
        ack_mask = mask;
        reg_addr = ra;
        data_in = d;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        active = 1'b1;
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!m_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!m_done) checkOutput("done_timeout", 32'(m_done), 32'(1));
    endtask

    // Target model and monitor: SCL falls index the slots, ACK slots are pulled low
    // unless masked, and each SCL rise and done pulse is scored against the queues.
    always @(negedge clk) begin
        if (rst) begin
            prev_scl = 1'b1;
            prev_sda = 1'b1;
            falls = 0;
            pull = 1'b0;
            active = 1'b0;
            busy_gap = 1'b0;
        end else begin
            if (prev_scl && m_scl && prev_sda && !m_sda) begin
                falls = 0;
                pull = 1'b0;
            end
            if (prev_scl && !m_scl) begin
                falls++;
                slot = falls - 1;
                pull = (slot < 27) && (slot % 9 == 8) && ack_mask[slot / 9];
            end
            if (!prev_scl && m_scl) begin
                if (exp_bits.size() == 0) begin
                    checkOutput("scl_pulse_expected", 32'(exp_bits.size()), 32'(1));
                end else begin
                    exp_b = exp_bits.pop_front();
                    checkOutput("sda_bit", 32'(m_sda), 32'(exp_b));
                end
            end
            if (m_done) begin
                done_count++;
                active = 1'b0;
                if (exp_cyc.size() == 0) begin
                    checkOutput("done_expected", 32'(exp_cyc.size()), 32'(1));
                end else begin
                    exp_c = exp_cyc.pop_front();
                    exp_n = exp_nk.pop_front();
                    checkOutput("done_cycle", 32'(cyc - start_cyc), 32'(exp_c));
                    checkOutput("nack_at_done", 32'(m_nack), 32'(exp_n));
                    checkOutput("bits_left", 32'(exp_bits.size()), 32'(0));
                    checkOutput("busy_at_done", 32'(m_busy), 32'(0));
                    checkOutput("bus_released", 32'({m_scl, m_sda}), 32'(2'b11));
                    checkOutput("busy_gap", 32'(busy_gap), 32'(0));
                end
                busy_gap = 1'b0;
            end else if (active && !m_busy) begin
                busy_gap = 1'b1;
            end
            prev_scl = m_scl;
            prev_sda = m_sda;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dc0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state_div4", 32'({scl4, sda4, busy4, done4, nack4}), 32'(5'b11000));
        checkOutput("reset_state_div1", 32'({scl1, sda1, busy1, done1, nack1}), 32'(5'b11000));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] full write, CLK_DIV=4");
        applyStimulus(8'h05, 8'hA5, 3'b111);
        waitDone(600);
        repeat (3) @(negedge clk);

        $display("[TB] address NACK");
        applyStimulus(8'h05, 8'hA5, 3'b110);
        waitDone(600);
        repeat (10) @(negedge clk);
        checkOutput("nack_hold_idle", 32'(m_nack), 32'(1));
        checkOutput("scl_idle", 32'(m_scl), 32'(1));

        $display("[TB] data NACK");
        applyStimulus(8'h05, 8'hA5, 3'b011);
        checkOutput("nack_cleared_on_start", 32'(m_nack), 32'(0));
        waitDone(600);
        repeat (3) @(negedge clk);

        $display("[TB] busy and latching");
        dc0 = done_count;
        applyStimulus(8'h05, 8'hA5, 3'b111);
        while (cyc - start_cyc < 50) @(negedge clk);
        reg_addr = 8'h3C;
        data_in = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc - start_cyc < 100) @(negedge clk);
        data_in = 8'hFF;
        waitDone(600);
        repeat (40) @(negedge clk);
        checkOutput("single_done", 32'(done_count - dc0), 32'(1));

        $display("[TB] reset mid-transfer");
        applyStimulus(8'h05, 8'hA5, 3'b111);
        while (cyc - start_cyc < 200) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_state", 32'({m_scl, m_sda_o, m_busy, m_nack, m_done}), 32'(5'b11000));
        exp_bits.delete();
        exp_cyc.delete();
        exp_nk.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        dc0 = done_count;
        repeat (300) @(negedge clk);
        checkOutput("no_done_after_reset", 32'(done_count - dc0), 32'(0));
        applyStimulus(8'h05, 8'hA5, 3'b111);
        waitDone(600);
        repeat (3) @(negedge clk);

        $display("[TB] CLK_DIV=1 boundary and back-to-back");
        sel = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(8'h05, 8'hA5, 3'b111);
        waitDone(200);
        @(negedge clk);
        applyStimulus(8'h7E, 8'h3C, 3'b111);
        waitDone(200);
        repeat (5) @(negedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
